// File: rtl/icache_refill_ctrl.sv
// Read-only direct-mapped instruction cache controller.
// Holds tag/valid state and refills lines word-serially into an external quad-port RAM.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_BITS  = 10,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpu_req,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  output logic                              cpu_ready,
  output logic                              cpu_ack,
  output logic [DATA_WIDTH-1:0]             cpu_rdata,
  input  logic                              flush,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic                              mem_rvalid,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              ram_we,
  output logic [INDEX_BITS+OFFSET_BITS-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  output logic [INDEX_BITS+OFFSET_BITS-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0]             ram_rdata,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
);

  localparam int unsigned RAM_AW    = INDEX_BITS + OFFSET_BITS;
  localparam int unsigned WADDR_W   = ADDR_WIDTH - 2;
  localparam int unsigned TAG_BITS  = WADDR_W - RAM_AW;
  localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_REREAD
  } state_e;

  state_e                 state_q, state_d;
  logic [WADDR_W-1:0]     waddr_q, waddr_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   refill_q, refill_d;
  logic [31:0]            hit_cnt_q, hit_cnt_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;
  logic [TAG_BITS-1:0]    tag_mem_q [NUM_LINES];
  logic                   tag_we;

  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   line_hit;
  logic                   unused_byte_bits;

  // Word address latched at request: {tag, index, offset}
  assign req_idx  = waddr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_tag  = waddr_q[RAM_AW +: TAG_BITS];
  assign line_hit = valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
  assign unused_byte_bits = ^cpu_addr[1:0];

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      beat_q     <= '0;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      beat_q     <= beat_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag storage needs no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem_q[req_idx] <= req_tag;
    end
  end

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    beat_d     = beat_q;
    valid_d    = valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    refill_d   = refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    tag_we     = 1'b0;
    cpu_ready  = 1'b0;
    cpu_ack    = 1'b0;
    cpu_rdata  = '0;
    ram_we     = 1'b0;
    ram_waddr  = {req_idx, beat_q};
    ram_wdata  = mem_rdata;
    ram_raddr  = waddr_q[RAM_AW-1:0];

    unique case (state_q)
      S_IDLE: begin
        cpu_ready = 1'b1;
        ram_raddr = cpu_addr[2 +: RAM_AW];
        if (flush) begin
          valid_d = '0;
        end else if (cpu_req) begin
          waddr_d = cpu_addr[ADDR_WIDTH-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (line_hit) begin
          cpu_ack   = 1'b1;
          cpu_rdata = ram_rdata;
          // The lookup that completes a refill was already counted as a miss
          if (!refill_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
          refill_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          mem_req_d  = 1'b1;
          mem_addr_d = {req_tag, req_idx, {(OFFSET_BITS + 2){1'b0}}};
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rvalid) begin
          mem_req_d = 1'b0;
          ram_we    = 1'b1;
          beat_d    = beat_q + OFFSET_BITS'(1);
          if (beat_q == LAST_BEAT) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            beat_d           = '0;
            refill_d         = 1'b1;
            state_d          = S_REREAD;
          end
        end
      end
      S_REREAD: begin
        state_d = S_LOOKUP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: behavioural RAM, scripted memory side,
// and a scoreboard of expected returned words popped on every cpu_ack.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [11:0] ram_raddr;
  logic [31:0] ram_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic [31:0] ram_mem [4096];
  logic [31:0] sb_q [$];
  logic [31:0] mon_exp;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  icache_refill_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // RAM: port A write, port C one-cycle synchronous read
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_raddr];
  end

  // Scoreboard: every ack must match the oldest outstanding expected word
  always @(negedge clk) begin
    if (rst_n && cpu_ack) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL ack_unexpected: rdata=%h, no request outstanding", cpu_rdata);
      end else begin
        mon_exp = sb_q.pop_front();
        if (cpu_rdata !== mon_exp) $display("FAIL ack_rdata: got %h, expected %h", cpu_rdata, mon_exp);
        else n_pass++;
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (cpu_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (cpu_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: cpu_ready=%b after %0d cycles, expected 1", cpu_ready, k);
    end
  endtask

  task automatic send_req(input logic [31:0] addr, input logic hit, input logic [31:0] exp_data,
                          input string name);
    wait_ready();
    cpu_addr = addr;
    cpu_req  = 1'b1;
    sb_q.push_back(exp_data);
    @(negedge clk);
    cpu_req = 1'b0;
    n_checks++;
    if (cpu_ack !== hit) $display("FAIL %s_lookup_ack: got %b, expected %b", name, cpu_ack, hit);
    else n_pass++;
    if (hit) begin
      exp_hits++;
      n_checks++;
      if (mem_req !== 1'b0) $display("FAIL %s_hit_mem_req: got %b, expected 0", name, mem_req);
      else n_pass++;
    end else begin
      exp_misses++;
    end
  endtask

  task automatic do_fill(input logic [31:0] exp_base, input logic [31:0] first, input logic [15:0] pat,
                         input int plen, input string name);
    int k = 0;
    int beats = 0;
    int we_cnt = 0;
    logic seen = 1'b0;
    while (mem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (mem_req !== 1'b1) begin
      $display("FAIL %s_mem_req: got %b after %0d cycles, expected 1", name, mem_req, k);
      return;
    end
    n_pass++;
    n_checks++;
    if (mem_addr !== exp_base) $display("FAIL %s_mem_addr: got %h, expected %h", name, mem_addr, exp_base);
    else n_pass++;
    for (int i = 0; i < plen; i++) begin
      mem_rvalid = pat[i];
      mem_rdata  = first + 32'(beats);
      #1;
      if (ram_we === 1'b1) we_cnt++;
      n_checks++;
      if (ram_we !== pat[i] || (pat[i] && (ram_waddr !== {exp_base[13:4], 2'(beats)} || ram_wdata !== mem_rdata)))
        $display("FAIL %s_beat%0d: we=%b waddr=%h wdata=%h, expected we=%b waddr=%h wdata=%h", name, i,
                 ram_we, ram_waddr, ram_wdata, pat[i], {exp_base[13:4], 2'(beats)}, mem_rdata);
      else n_pass++;
      if (pat[i]) beats++;
      @(negedge clk);
      if (pat[i] && !seen) begin
        seen = 1'b1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL %s_mem_req_drop: got %b, expected 0", name, mem_req);
        else n_pass++;
      end
    end
    mem_rvalid = 1'b0;
    n_checks++;
    if (we_cnt != 4) $display("FAIL %s_we_pulses: got %0d, expected 4", name, we_cnt);
    else n_pass++;
    n_checks++;
    if (cpu_ack !== 1'b0) $display("FAIL %s_reread_ack: got %b, expected 0", name, cpu_ack);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1) $display("FAIL %s_refill_ack: got %b, expected 1", name, cpu_ack);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b0 || mem_req !== 1'b0 || ram_we !== 1'b0 || cpu_rdata !== 32'h0 || mem_addr !== 32'h0)
      $display("FAIL reset_outputs: ack=%b mem_req=%b we=%b rdata=%h mem_addr=%h, expected all 0",
               cpu_ack, mem_req, ram_we, cpu_rdata, mem_addr);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 || hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL reset_release: ready=%b hits=%0d misses=%0d, expected 1/0/0", cpu_ready, hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic check_counters(input string name);
    @(negedge clk);
    n_checks++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses))
      $display("FAIL %s_counters: hits=%0d misses=%0d, expected %0d/%0d", name, hit_count, miss_count,
               exp_hits, exp_misses);
    else n_pass++;
  endtask

  task automatic test_cold_miss();
    send_req(32'h0000_1004, 1'b0, 32'hA1, "cold");
    do_fill(32'h0000_1000, 32'hA0, 16'h000F, 4, "cold");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram_mem[12'h400 + 12'(i)] !== 32'hA0 + 32'(i))
        $display("FAIL cold_ram_word%0d: got %h, expected %h", i, ram_mem[12'h400 + 12'(i)], 32'hA0 + 32'(i));
      else n_pass++;
    end
    check_counters("cold");
  endtask

  task automatic test_hit();
    send_req(32'h0000_100C, 1'b1, 32'hA3, "hit");
    check_counters("hit");
  endtask

  task automatic test_conflict();
    send_req(32'h0000_5004, 1'b0, 32'hB1, "conflict");
    do_fill(32'h0000_5000, 32'hB0, 16'h000F, 4, "conflict");
    check_counters("conflict");
    send_req(32'h0000_1004, 1'b0, 32'hA1, "evicted");
    do_fill(32'h0000_1000, 32'hA0, 16'h000F, 4, "evicted");
    check_counters("evicted");
  endtask

  task automatic test_flush();
    wait_ready();
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_1004;
    @(negedge clk);
    flush   = 1'b0;
    cpu_req = 1'b0;
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_ack !== 1'b0)
      $display("FAIL flush_drop: ready=%b ack=%b, expected 1/0", cpu_ready, cpu_ack);
    else n_pass++;
    send_req(32'h0000_5004, 1'b0, 32'hB1, "post_flush");
    do_fill(32'h0000_5000, 32'hB0, 16'h000F, 4, "post_flush");
    wait_ready();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    send_req(32'h0000_5004, 1'b0, 32'hB1, "reflush");
    do_fill(32'h0000_5000, 32'hB0, 16'h000F, 4, "reflush");
    check_counters("flush");
  endtask

  task automatic test_reset_mid_fill();
    int k = 0;
    send_req(32'h0000_2008, 1'b0, 32'hC2, "abandon");
    while (mem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hC0 + 32'(i);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_hits   = 0;
    exp_misses = 0;
    n_checks++;
    if (cpu_ack !== 1'b0 || mem_req !== 1'b0 || ram_we !== 1'b0 || cpu_rdata !== 32'h0 || mem_addr !== 32'h0 ||
        hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL midfill_reset: ack=%b mem_req=%b we=%b rdata=%h mem_addr=%h hits=%0d misses=%0d, expected all 0",
               cpu_ack, mem_req, ram_we, cpu_rdata, mem_addr, hit_count, miss_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    send_req(32'h0000_2008, 1'b0, 32'hC2, "rerequest");
    do_fill(32'h0000_2000, 32'hC0, 16'h000F, 4, "rerequest");
    check_counters("rerequest");
  endtask

  task automatic test_gapped_fill();
    send_req(32'h0000_3004, 1'b0, 32'hD1, "gapped");
    do_fill(32'h0000_3000, 32'hD0, 16'h0059, 7, "gapped");
    check_counters("gapped");
  endtask

  task automatic test_back_to_back();
    send_req(32'h0000_3000, 1'b1, 32'hD0, "b2b_a");
    send_req(32'h0000_300C, 1'b1, 32'hD3, "b2b_b");
    send_req(32'h0000_2008, 1'b1, 32'hC2, "b2b_c");
    check_counters("b2b");
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d acks missing, expected 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_gapped_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Read-only, direct-mapped cache controller that sits directly upstream of parameterized_quad_port_ram.
- It drives one write port of the RAM for line refills and one synchronous read port for CPU lookups.
- It holds the tag and valid arrays internally, and fetches missing lines from a word-serial memory interface.
- Default geometry: 1024 lines x 4 words x 32 bits, which maps onto a 4096x32 RAM with a 12-bit address.

Parameters:
ADDR_WIDTH, 32, CPU byte-address width
DATA_WIDTH, 32, word width (must match RAM)
INDEX_BITS, 10, log2 number of lines
OFFSET_BITS, 2, log2 words per line; RAM address width = INDEX_BITS+OFFSET_BITS

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  lookup request, sampled only while cpu_ready=1
cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
cpu_ready  out  1  controller is idle and can accept a request
cpu_ack  out  1  one-cycle pulse; cpu_rdata is valid while it is high
cpu_rdata  out  DATA_WIDTH  returned word
flush  in  1  invalidate all lines
mem_req  out  1  line fetch request, held high until first mem_rvalid
mem_addr  out  ADDR_WIDTH  line-aligned byte address (offset and byte bits zero)
mem_rvalid  in  1  one refill word per cycle when high, in ascending order
mem_rdata  in  DATA_WIDTH  refill word
ram_we  out  1  to RAM we_a
ram_waddr  out  INDEX_BITS+OFFSET_BITS  to RAM addr_a
ram_wdata  out  DATA_WIDTH  to RAM data_a
ram_raddr  out  INDEX_BITS+OFFSET_BITS  to RAM read port address (addr_c)
ram_rdata  in  DATA_WIDTH  from RAM q_c; one-cycle synchronous read
hit_count  out  32  lookups that hit, wraps at 2^32
miss_count  out  32  lookups that missed, wraps at 2^32

Behaviour:
- Address split:
  - word offset = cpu_addr[OFFSET_BITS+1:2]
  - index = next INDEX_BITS bits
  - tag = remaining upper bits
- Reset (rst_n=0, async):
  - state IDLE, all valid bits 0, beat counter 0, both counters 0
  - cpu_ack=0, mem_req=0, ram_we=0, cpu_rdata=0, mem_addr=0
  - cpu_ready=1 once rst_n is released
- IDLE:
  - cpu_ready=1.
  - ram_raddr = {index, offset} taken combinationally from cpu_addr.
  - flush=1: clear all valid bits at that edge, stay in IDLE. flush has priority over a same-cycle cpu_req; that request is dropped.
  - cpu_req=1 (no flush): latch the address, go to LOOKUP.
- LOOKUP: ram_raddr driven from the latched address.
  - Hit (valid[index] and stored tag equal): cpu_ack=1 and cpu_rdata=ram_rdata during this cycle; hit_count+1; go to IDLE.
  - Hit latency: ack in the cycle immediately after the request edge.
  - Miss: miss_count+1, go to FILL, mem_req=1, mem_addr = line base.
- FILL:
  - mem_req drops at the edge where the first mem_rvalid is sampled.
  - Each mem_rvalid cycle: ram_we=1, ram_waddr = {index, beat}, ram_wdata = mem_rdata, beat+1.
  - Gaps in mem_rvalid are allowed.
  - On the last beat (beat = 2^OFFSET_BITS-1): write tag, set valid[index], reset beat to 0, go to REREAD.
- REREAD: one cycle with ram_raddr = latched {index, offset}, then go to LOOKUP. That LOOKUP hits and acks; the refill is not counted a second time in hit_count.
- Outside IDLE: cpu_ready=0, cpu_req and flush are ignored (not queued), and mem_rvalid outside FILL is ignored.
- Reset during FILL:
  - the line stays invalid, because valid is set only on the last beat
  - partially written RAM words are harmless
  - the memory side must tolerate an abandoned burst
- Replacement:
  - a conflicting tag on the same index overwrites the line
  - no write path, so no writeback
- Signals not described above are held at 0 when inactive: cpu_ack, ram_we, mem_req.

Test Plan:
- Cold miss:
  - After reset, cpu_req with cpu_addr=0x00001004 -> miss_count=1, mem_addr=0x00001000.
  - Supply 0xA0,0xA1,0xA2,0xA3 -> RAM words 0x400..0x403 written.
  - cpu_ack with cpu_rdata=0xA1; hit_count=0.
- Hit: cpu_req with 0x0000100C -> cpu_ack exactly one cycle after the request edge, cpu_rdata=0xA3, hit_count=1, mem_req stays 0.
- Conflict:
  - cpu_req with 0x00005004 (same index 0x100, tag 1) -> miss, mem_addr=0x00005000.
  - Refill 0xB0..0xB3 -> rdata=0xB1.
  - Then 0x00001004 -> misses again.
- Flush: flush and cpu_req in the same IDLE cycle -> request dropped; subsequent 0x00005004 -> miss, mem_req=1.
- Reset mid-refill:
  - Miss on 0x00002008; deliver 2 beats, pulse rst_n=0 -> all outputs 0, counters 0.
  - Re-request 0x00002008 -> miss, mem_addr=0x00002000.
- Gapped refill: mem_rvalid pattern 1,0,0,1,1,0,1 -> exactly 4 ram_we pulses at addresses {idx,0..3}; ack follows 2 cycles after the last beat (REREAD then LOOKUP).
